// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: datapath widths,
// ALU select encodings, scheduler states and the illegal-select decode.
package alu_pkg;

   localparam int DATA_W = 4;
   localparam int SEL_W  = 3;
   localparam int ID_W   = 2;

   typedef enum logic [SEL_W-1:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      OR  = 3'b011,
      XOR = 3'b100,
      SLT = 3'b101
   } alu_sel_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } sched_state_t;

   // Codes 110 and 111 have no ALU operation behind them.
   function automatic logic is_illegal_sel(input logic [SEL_W-1:0] sel);
      return sel[2] & sel[1];
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the requesters/consumer and the scheduler.
// Requests are per-requester vectors; the response side is a single channel.
interface alu_rr_scheduler_if import alu_pkg::*; #(
   parameter int NREQ = 4
);

   logic [NREQ-1:0]             req_valid;
   logic [NREQ-1:0][DATA_W-1:0] req_a;
   logic [NREQ-1:0][DATA_W-1:0] req_b;
   logic [NREQ-1:0][SEL_W-1:0]  req_sel;
   logic [NREQ-1:0]             req_ready;

   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [ID_W-1:0]             rsp_id;
   logic [DATA_W-1:0]           rsp_result;
   logic                        rsp_carry;
   logic                        rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err
   );

endinterface

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU. Unknown select codes produce zero result and carry;
// flagging them as errors is left to the caller.
module alu_4bit import alu_pkg::*; (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum_ext;
   logic [DATA_W:0] diff_ext;

   // Operation select; subtraction wraps modulo 2^(DATA_W+1) so the top bit is the borrow.
   always_comb begin
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      result   = '0;
      carry    = 1'b0;
      case (sel)
         ADD:     {carry, result} = sum_ext;
         SUB:     {carry, result} = diff_ext;
         AND:     result = a & b;
         OR:      result = a | b;
         XOR:     result = a ^ b;
         SLT:     result = {{(DATA_W-1){1'b0}}, (a < b)};
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter in front of one shared ALU. A grant latches the winner's
// operands, the ALU result is registered one cycle later, and the response is
// held until the consumer accepts it. One operation is in flight at a time.
module alu_rr_scheduler import alu_pkg::*; #(
   parameter int NREQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   alu_rr_scheduler_if.slave  bus,
   output logic               busy
);

   sched_state_t      state_reg;
   sched_state_t      state_next;

   logic [ID_W-1:0]   ptr_reg;
   logic [ID_W-1:0]   id_reg;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [SEL_W-1:0]  sel_reg;

   logic [ID_W-1:0]   rsp_id_reg;
   logic [DATA_W-1:0] rsp_result_reg;
   logic              rsp_carry_reg;
   logic              rsp_err_reg;

   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W-1:0]   cand;
   logic [NREQ-1:0]   grant_vec;
   logic              grant_fire;

   // Search upward from the pointer, wrapping, for the first valid requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_reg + ID_W'(k);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_grant
         assign grant_vec[gi] = win_found && (win_idx == ID_W'(gi));
      end
   endgenerate

   // Grants are only offered from IDLE and never while reset is asserted.
   assign grant_fire    = (state_reg == IDLE) && win_found;
   assign bus.req_ready = ((state_reg == IDLE) && !rst) ? grant_vec : '0;

   // Next-state logic for the IDLE -> EXEC -> RESP sequence.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (win_found) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture the winner's operation and advance the round-robin pointer past it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
         id_reg  <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         sel_reg <= '0;
      end else if (grant_fire) begin
         ptr_reg <= win_idx + ID_W'(1);
         id_reg  <= win_idx;
         a_reg   <= bus.req_a[win_idx];
         b_reg   <= bus.req_b[win_idx];
         sel_reg <= bus.req_sel[win_idx];
      end
   end

   alu_4bit u_alu (
      .a      (a_reg),
      .b      (b_reg),
      .sel    (sel_reg),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Register the ALU outcome during EXEC; it stays put until the next operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_id_reg     <= '0;
         rsp_result_reg <= '0;
         rsp_carry_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
      end else if (state_reg == EXEC) begin
         rsp_id_reg     <= id_reg;
         rsp_result_reg <= alu_result;
         rsp_carry_reg  <= alu_carry;
         rsp_err_reg    <= is_illegal_sel(sel_reg);
      end
   end

   assign bus.rsp_valid  = (state_reg == RESP);
   assign bus.rsp_id     = rsp_id_reg;
   assign bus.rsp_result = rsp_result_reg;
   assign bus.rsp_carry  = rsp_carry_reg;
   assign bus.rsp_err    = rsp_err_reg;
   assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a reference model predicts each grant
// from the arbitration rules and queues the expected response; a separate
// monitor compares whatever response the scheduler presents.
module tb_alu_rr_scheduler;
   import alu_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   always #5 clk = ~clk;

   alu_rr_scheduler_if #(.NREQ(N)) bus ();

   alu_rr_scheduler #(.NREQ(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   typedef struct {
      int id;
      int result;
      int carry;
      int err;
   } rsp_t;

   rsp_t exp_q[$];
   int   grant_log[$];
   int   checks = 0;
   int   errors = 0;
   int   m_ptr = 0;
   int   m_phase = 0;  // 0 waiting for grant, 1 executing, 2 response offered

   function automatic rsp_t ref_alu(input int id, input int a, input int b, input int sel);
      rsp_t r;
      r.id = id; r.result = 0; r.carry = 0; r.err = 0;
      case (sel)
         0: begin r.result = (a + b) % 16; r.carry = ((a + b) > 15) ? 1 : 0; end
         1: begin r.result = (a - b + 32) % 16; r.carry = (a < b) ? 1 : 0; end
         2: r.result = a & b;
         3: r.result = a | b;
         4: r.result = a ^ b;
         5: r.result = (a < b) ? 1 : 0;
         default: r.err = 1;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: predicts the grant for the coming edge and the state of busy/rsp_valid.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_ptr = 0;
            m_phase = 0;
            exp_q.delete();
            check("rst_req_ready", int'(bus.req_ready), 0);
            check("rst_rsp_valid", int'(bus.rsp_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_rsp_id", int'(bus.rsp_id), 0);
            check("rst_rsp_result", int'(bus.rsp_result), 0);
            check("rst_rsp_carry", int'(bus.rsp_carry), 0);
            check("rst_rsp_err", int'(bus.rsp_err), 0);
         end else begin
            check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
            check("rsp_valid", int'(bus.rsp_valid), (m_phase == 2) ? 1 : 0);
            if (m_phase == 0) begin
               int w;
               w = -1;
               for (int k = 0; k < N; k++) begin
                  int idx;
                  idx = (m_ptr + k) % N;
                  if (w < 0 && bus.req_valid[idx]) w = idx;
               end
               if (w < 0) begin
                  check("req_ready_none", int'(bus.req_ready), 0);
               end else begin
                  check("grant", int'(bus.req_ready), 1 << w);
                  exp_q.push_back(ref_alu(w, int'(bus.req_a[w]), int'(bus.req_b[w]),
                                          int'(bus.req_sel[w])));
                  grant_log.push_back(w);
                  m_ptr = (w + 1) % N;
                  m_phase = 1;
               end
            end else begin
               check("req_ready_busy", int'(bus.req_ready), 0);
               if (m_phase == 1) m_phase = 2;
               else if (bus.rsp_ready) m_phase = 0;
            end
         end
      end
   end

   // Monitor: compares every presented response against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected actual id=%0d result=%0d required no response",
                        bus.rsp_id, bus.rsp_result);
            end else begin
               rsp_t e;
               e = exp_q[0];
               check("rsp_id", int'(bus.rsp_id), e.id);
               check("rsp_result", int'(bus.rsp_result), e.result);
               check("rsp_carry", int'(bus.rsp_carry), e.carry);
               check("rsp_err", int'(bus.rsp_err), e.err);
               if (bus.rsp_ready) begin
                  void'(exp_q.pop_front());
                  $display("RSP id=%0d result=%h carry=%0d err=%0d", bus.rsp_id,
                           bus.rsp_result, bus.rsp_carry, bus.rsp_err);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (!busy && !bus.rsp_valid) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
      tick();
   endtask

   // Single request from requester i; operands are scrambled right after the handshake.
   task automatic issue(input int i, input int a, input int b, input int sel);
      bit got;
      bus.req_valid = '0;
      bus.req_valid[i] = 1'b1;
      bus.req_a[i] = 4'(a);
      bus.req_b[i] = 4'(b);
      bus.req_sel[i] = 3'(sel);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.req_ready[i]) got = 1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout req=%0d actual=no grant required=grant", i);
      end
      tick();
      bus.req_valid[i] = 1'b0;
      bus.req_a[i] = 4'($urandom_range(0, 15));
      bus.req_b[i] = 4'($urandom_range(0, 15));
      bus.req_sel[i] = 3'($urandom_range(0, 7));
      wait_idle();
   endtask

   task automatic randomize_operands();
      for (int k = 0; k < N; k++) begin
         bus.req_a[k] = 4'($urandom_range(0, 15));
         bus.req_b[k] = 4'($urandom_range(0, 15));
         bus.req_sel[k] = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int base;
      bit got;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_sel = '0;
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Directed add, subtract, illegal and compare cases.
      issue(2, 9, 7, 0);
      issue(0, 3, 5, 1);
      issue(0, 5, 3, 1);
      issue(3, 15, 15, 6);
      issue(1, 2, 10, 5);

      // Round robin with all four requesters valid, starting from a fresh pointer.
      pulse_reset();
      base = grant_log.size();
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         randomize_operands();
         tick();
      end
      bus.req_valid = '0;
      wait_idle();
      check("rr_grant_count_ge6", (grant_log.size() - base >= 6) ? 1 : 0, 1);
      if (grant_log.size() - base >= 6) begin
         for (int k = 0; k < 6; k++) check("rr_order", grant_log[base + k], k % 4);
      end

      // Backpressure: response held while the consumer stalls and others request.
      bus.rsp_ready = 1'b0;
      bus.req_valid = '0;
      bus.req_valid[1] = 1'b1;
      bus.req_a[1] = 4'd6;
      bus.req_b[1] = 4'd3;
      bus.req_sel[1] = 3'd2;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.rsp_valid) got = 1;
      end
      check("bp_rsp_seen", int'(got), 1);
      tick();
      bus.req_valid = '1;
      randomize_operands();
      repeat (5) tick();
      bus.rsp_ready = 1'b1;
      bus.req_valid = '0;
      wait_idle();

      // Reset during EXEC discards the operation; priority restarts at index 0.
      bus.req_valid = '0;
      bus.req_valid[2] = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.req_ready[2]) got = 1;
      end
      check("mid_rst_grant_seen", int'(got), 1);
      tick();
      rst = 1'b1;
      bus.req_valid = 4'b1010;
      tick();
      rst = 1'b0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (bus.req_ready != '0) got = 1;
      end
      check("post_rst_grant", int'(bus.req_ready), 2);
      tick();
      bus.req_valid = '0;
      wait_idle();

      // Random traffic with random backpressure.
      for (int c = 0; c < 300; c++) begin
         bus.req_valid = 4'($urandom_range(0, 15));
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         randomize_operands();
         tick();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      wait_idle();
      check("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
